// File: rtl/tone_det_pkg.sv
// Shared types and helpers for the tone direction decoder.
// Holds the FSM state type, the direction-code layout and the legacy
// per-channel direction constants used by five-channel integrations.
package tone_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HOLD    = 2'd2,
    REARM   = 2'd3
  } state_e;

  // Widest index field supported (NUM_CH up to 8)
  localparam int unsigned MAX_IDX_W = 3;

  // Stop-flag position in the widest direction code; a narrower build
  // places the flag directly above its own index field
  localparam int unsigned STOP_BIT = MAX_IDX_W;

  // Legacy 3-bit direction codes for five-channel users
  localparam logic [2:0] LEGACY_DIR_CH0 = 3'd0;
  localparam logic [2:0] LEGACY_DIR_CH1 = 3'd1;
  localparam logic [2:0] LEGACY_DIR_CH2 = 3'd2;
  localparam logic [2:0] LEGACY_DIR_CH3 = 3'd3;
  localparam logic [2:0] LEGACY_DIR_CH4 = 3'd4;

  // Build a {stop, idx} code with the stop flag at bit idx_w; bits above
  // idx_w are zero so callers can slice out [idx_w:0]
  function automatic logic [MAX_IDX_W:0] mk_dir(input logic                 stop,
                                                input logic [MAX_IDX_W-1:0] idx,
                                                input int unsigned          idx_w);
    logic [MAX_IDX_W:0] mask;
    mask = ({{MAX_IDX_W{1'b0}}, 1'b1} << idx_w) - 1'b1;
    return ({1'b0, idx} & mask) | ({{MAX_IDX_W{1'b0}}, stop} << idx_w);
  endfunction

endpackage

// File: rtl/tone_qual_channel.sv
// One tone channel's qualify tracker: counts consecutive-high samples,
// tolerating low runs up to GAP_CYCLES, and flags the sample that
// completes a QUAL_CYCLES run.
module tone_qual_channel #(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned QUAL_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic tone_i,
  output logic hit_o,
  output logic active_o
);

  localparam logic [CNT_W-1:0] QUAL_MAX  = CNT_W'(QUAL_CYCLES);
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(GAP_CYCLES);

  logic [CNT_W-1:0] qual_q, qual_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  // This sample brings the run to QUAL_CYCLES
  assign hit_o    = en_i && tone_i && (qual_q >= QUAL_LAST);
  assign active_o = |qual_q;

  // Next-state for the run and dropout counters
  always_comb begin
    qual_d = qual_q;
    gap_d  = gap_q;
    if (clr_i) begin
      qual_d = '0;
      gap_d  = '0;
    end else if (en_i) begin
      if (tone_i) begin
        qual_d = (qual_q >= QUAL_MAX) ? QUAL_MAX : qual_q + CNT_W'(1);
        gap_d  = '0;
      end else if (gap_q >= GAP_MAX) begin
        qual_d = '0;
        gap_d  = '0;
      end else begin
        gap_d = gap_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_q <= '0;
      gap_q  <= '0;
    end else begin
      qual_q <= qual_d;
      gap_q  <= gap_d;
    end
  end

endmodule

// File: rtl/tone_direction_decoder.sv
// N-channel tone qualifier and direction decoder.
// A channel whose tone persists for QUAL_CYCLES (with dropouts up to
// GAP_CYCLES) is presented as {0, idx} for HOLD_CYCLES or until
// junction_ack, then STOP; re-arms once all tones are low.
// Build option: define TONE_SYNC_EN to pass tone_in through a 2-flop
// synchroniser per bit (adds 2 cycles of latency).
module tone_direction_decoder
  import tone_det_pkg::*;
#(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned IDX_W       = $clog2(NUM_CH),
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned QUAL_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] tone_in,
  input  logic              junction_ack,
  output logic [IDX_W:0]    td_dir,
  output logic              td_valid,
  output logic              busy
);

  localparam logic [MAX_IDX_W:0] STOP_FULL = mk_dir(1'b1, '0, IDX_W);
  localparam logic [IDX_W:0]     DIR_STOP  = STOP_FULL[IDX_W:0];
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [NUM_CH-1:0] tone_s;

`ifdef TONE_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for the asynchronous tone flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
    end
  end

  assign tone_s = sync2_q;
`else
  assign tone_s = tone_in;
`endif

  state_e           state_q;
  logic [IDX_W:0]   td_dir_q;
  logic             td_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic              cnt_en;
  logic              cnt_clr;
  logic              any_hit;
  logic              any_active;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] active;
  logic [IDX_W-1:0]  win_idx;
  logic [MAX_IDX_W:0] win_full;
  logic [IDX_W:0]    win_dir;

  assign cnt_en     = (state_q == IDLE) || (state_q == QUALIFY);
  assign any_hit    = |hit;
  assign any_active = |active;
  // Counters run only while arming and restart from zero once a channel wins
  assign cnt_clr    = !cnt_en || any_hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tone_qual_channel #(
      .CNT_W      (CNT_W),
      .QUAL_CYCLES(QUAL_CYCLES),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (cnt_en),
      .clr_i   (cnt_clr),
      .tone_i  (tone_s[g]),
      .hit_o   (hit[g]),
      .active_o(active[g])
    );
  end

  // Priority encoder: lowest qualifying index wins
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hit[NUM_CH-1-i]) win_idx = IDX_W'(NUM_CH - 1 - i);
    end
  end

  assign win_full = mk_dir(1'b0, MAX_IDX_W'(win_idx), IDX_W);
  assign win_dir  = win_full[IDX_W:0];

  // Control FSM with registered direction, valid pulse, busy and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      td_dir_q   <= DIR_STOP;
      td_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      td_valid_q <= 1'b0;
      case (state_q)
        IDLE, QUALIFY: begin
          if (any_hit) begin
            state_q    <= HOLD;
            td_dir_q   <= win_dir;
            td_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end else if (state_q == IDLE && any_active) begin
            state_q <= QUALIFY;
          end else if (state_q == QUALIFY && !any_active) begin
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (junction_ack || hold_cnt_q == HOLD_LAST) begin
            state_q    <= REARM;
            td_dir_q   <= DIR_STOP;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        REARM: begin
          if (tone_s == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          td_dir_q   <= DIR_STOP;
          busy_q     <= 1'b0;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign td_dir   = td_dir_q;
  assign td_valid = td_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tone_direction_decoder.sv
// Directed bench for tone_direction_decoder (QUAL=8, GAP=2, HOLD=16, 5 ch).
module tb_tone_direction_decoder;
  import tone_det_pkg::*;

`ifdef TONE_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  localparam logic [3:0] STOP = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] tone_in;
  logic       junction_ack;
  logic [3:0] td_dir;
  logic       td_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  tone_direction_decoder #(
    .NUM_CH     (5),
    .CNT_W      (25),
    .QUAL_CYCLES(8),
    .GAP_CYCLES (2),
    .HOLD_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .junction_ack(junction_ack),
    .td_dir      (td_dir),
    .td_valid    (td_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (td_valid === 1'b1) pulses++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    tone_in      = '0;
    junction_ack = 1'b0;
    #12;
    check("rst_dir", td_dir, STOP);
    check("rst_valid", td_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dut.state_q, IDLE);
    rst_n = 1'b1;
    tick(2);

    // Basic qualify on channel 2
    tone_in = 5'b00100;
    tick(7 + S);
    check("s1_pre_dir", td_dir, STOP);
    check("s1_pre_valid", td_valid, 1'b0);
    tick(1);
    check("s1_dir", td_dir, 4'b0010);
    check("s1_valid", td_valid, 1'b1);
    check("s1_busy", busy, 1'b1);
    tick(1);
    check("s1_valid_drop", td_valid, 1'b0);
    tick(14);
    check("s1_hold_last", td_dir, 4'b0010);
    tick(1);
    check("s1_stop", td_dir, STOP);
    check("s1_busy_rearm", busy, 1'b1);
    tick(3);
    check("s1_rearm_held", busy, 1'b1);
    check("s1_pulses", pulses, 1);
    tone_in = '0;
    tick(1 + S);
    check("s1_rearm_exit", busy, 1'b0);
    check("s1_idle", dut.state_q, IDLE);
    tick(3);

    // Dropout of 2 tolerated, then early release by ack at hold cycle 5
    tone_in = 5'b00010;
    tick(4);
    tone_in = '0;
    tick(2);
    tone_in = 5'b00010;
    tick(3 + S);
    check("s2_pre_dir", td_dir, STOP);
    tick(1);
    check("s2_dir", td_dir, 4'b0001);
    check("s2_valid", td_valid, 1'b1);
    tick(4);
    junction_ack = 1'b1;
    tick(1);
    junction_ack = 1'b0;
    check("s2_ack_stop", td_dir, STOP);
    check("s2_ack_busy", busy, 1'b1);
    tick(10);
    check("s2_no_retrig_dir", td_dir, STOP);
    check("s2_no_retrig_busy", busy, 1'b1);
    check("s2_pulses", pulses, 2);
    tone_in = '0;
    tick(1 + S);
    check("s2_rearm_exit", busy, 1'b0);
    tone_in = 5'b00010;
    tick(7 + S);
    check("s2_fresh_pre", td_dir, STOP);
    tick(1);
    check("s2_fresh_dir", td_dir, 4'b0001);
    check("s2_fresh_valid", td_valid, 1'b1);
    tick(15);
    check("s2_fresh_hold", td_dir, 4'b0001);
    tick(1);
    check("s2_fresh_stop", td_dir, STOP);
    check("s2_fresh_pulses", pulses, 3);
    tone_in = '0;
    tick(1 + S);
    check("s2_idle", busy, 1'b0);
    tick(3);

    // Dropout of 3 exceeds tolerance: no qualify, back to IDLE
    tone_in = 5'b00010;
    tick(4);
    tone_in = '0;
    tick(3);
    tone_in = 5'b00010;
    tick(4);
    tone_in = '0;
    tick(3 + S);
    check("s3_state_qual", dut.state_q, QUALIFY);
    check("s3_dir", td_dir, STOP);
    tick(1);
    check("s3_state_idle", dut.state_q, IDLE);
    check("s3_busy", busy, 1'b0);
    check("s3_pulses", pulses, 3);
    tick(2);

    // Tie between channels 3 and 1; ack on the latch edge is ignored
    tone_in = 5'b01010;
    tick(7 + S);
    junction_ack = 1'b1;
    tick(1);
    junction_ack = 1'b0;
    check("s4_tie_dir", td_dir, 4'b0001);
    check("s4_tie_busy", busy, 1'b1);
    tick(1);
    check("s4_ack_ignored", td_dir, 4'b0001);
    junction_ack = 1'b1;
    tick(1);
    junction_ack = 1'b0;
    check("s4_ack_stop", td_dir, STOP);
    tone_in = '0;
    tick(1 + S);
    check("s4_idle", busy, 1'b0);
    check("s4_pulses", pulses, 4);
    tick(2);

    // Channel 4 rises one cycle before channel 0 and wins
    tone_in = 5'b10000;
    tick(1);
    tone_in = 5'b10001;
    tick(6 + S);
    check("s5_pre_dir", td_dir, STOP);
    tick(1);
    check("s5_dir", td_dir, 4'b0100);
    tick(3);

    // Asynchronous reset mid-HOLD
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_rst_dir", td_dir, STOP);
    check("s6_rst_busy", busy, 1'b0);
    check("s6_rst_valid", td_valid, 1'b0);
    check("s6_rst_state", dut.state_q, IDLE);
    tone_in = '0;
    tick(2);
    #2;
    rst_n = 1'b1;
    tick(20);
    check("s6_pulses", pulses, 5);
    check("s6_dir", td_dir, STOP);
    check("s6_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
